// File: rtl/mmac_pkg.sv
// Shared constants and types for the time-multiplexed matrix multiply sequencer.
package mmac_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MAT_DIM    = 4;
    localparam int IDX_W      = $clog2(MAT_DIM);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        OUT
    } mmac_seq_state_t;

endpackage

// File: rtl/mmac_mac_step.sv
// Single multiply-accumulate step: clear loads the product, otherwise the product is added.
module mmac_mac_step #(
    parameter int DATA_WIDTH = mmac_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] product;
    logic [DATA_WIDTH-1:0] acc_reg;

    // Product and sum both wrap at DATA_WIDTH bits.
    assign product = a * b;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (enable) begin
            acc_reg <= clear ? product : acc_reg + product;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/mmac_sequencer.sv
// Loads A then B, runs one shared MAC over k for each (i,j), and streams C out row-major.
module mmac_sequencer #(
    parameter int DATA_WIDTH = mmac_pkg::DATA_WIDTH,
    parameter int MAT_DIM    = mmac_pkg::MAT_DIM
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(MAT_DIM)-1:0] out_row,
    output logic [$clog2(MAT_DIM)-1:0] out_col,
    output logic                       busy,
    output logic                       done
);
    import mmac_pkg::*;

    localparam int ROW_W  = $clog2(MAT_DIM);
    localparam int CELLS  = MAT_DIM * MAT_DIM;
    localparam int BEAT_W = 2 * ROW_W + 1;
    // MAT_DIM is a power of two, so the last index and last beat are all-ones.
    localparam logic [ROW_W-1:0]  IDX_LAST  = '1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = '1;

    mmac_seq_state_t       state_reg;
    logic [BEAT_W-1:0]     beat_reg;
    logic [ROW_W-1:0]      i_reg;
    logic [ROW_W-1:0]      j_reg;
    logic [ROW_W-1:0]      k_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic [DATA_WIDTH-1:0] a_mem [CELLS];
    logic [DATA_WIDTH-1:0] b_mem [CELLS];

    logic                  beat_fire;
    logic                  out_fire;
    logic                  mac_enable;
    logic                  mac_clear;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [DATA_WIDTH-1:0] acc;

    assign beat_fire = (state_reg == LOAD) && in_valid && in_ready_reg;
    assign out_fire  = (state_reg == OUT) && out_valid_reg && out_ready;

    // The top beat bit selects the B buffer; the low bits are the row-major cell index.
    always_ff @(posedge clock) begin
        if (beat_fire) begin
            if (beat_reg[BEAT_W-1]) begin
                b_mem[beat_reg[BEAT_W-2:0]] <= in_data;
            end else begin
                a_mem[beat_reg[BEAT_W-2:0]] <= in_data;
            end
        end
    end

    assign mac_a      = a_mem[{i_reg, k_reg}];
    assign mac_b      = b_mem[{k_reg, j_reg}];
    assign mac_enable = (state_reg == COMPUTE);
    assign mac_clear  = (k_reg == '0);

    mmac_mac_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .enable(mac_enable),
        .clear (mac_clear),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= LOAD;
                        beat_reg     <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_fire) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (beat_reg == BEAT_LAST) begin
                            state_reg    <= COMPUTE;
                            in_ready_reg <= 1'b0;
                            i_reg        <= '0;
                            j_reg        <= '0;
                            k_reg        <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    k_reg <= k_reg + 1'b1;
                    if (k_reg == IDX_LAST) begin
                        state_reg     <= OUT;
                        out_valid_reg <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        j_reg         <= j_reg + 1'b1;
                        if (j_reg == IDX_LAST) begin
                            i_reg <= i_reg + 1'b1;
                        end
                        if ((i_reg == IDX_LAST) && (j_reg == IDX_LAST)) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= COMPUTE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = acc;
    assign out_row   = i_reg;
    assign out_col   = j_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_mmac_sequencer.sv
// Table-driven check of the matrix multiply sequencer with stall, abort and back-to-back cases.
module tb_mmac_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] c [16];
        int         stall_at;
        bit         toggle;
    } vec_t;

    vec_t       vt [4];
    logic [7:0] sq_c [16];

    mmac_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("load_in_ready", in_ready, 1);
    endtask

    task automatic load_body(input int v);
        int beat;
        int cyc;
        beat = 0;
        cyc  = 0;
        while (beat < 32 && cyc < 500) begin
            in_valid = vt[v].toggle ? ((cyc % 3) != 1) : 1'b1;
            in_data  = (beat < 16) ? vt[v].a[beat] : vt[v].b[beat-16];
            if (in_valid && in_ready) beat++;
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_beats", beat, 32);
    endtask

    // Counts cycles from the final accepted beat to the first out_valid; optionally pokes start/in_valid.
    task automatic wait_first(input int v);
        int lat;
        lat = 1;
        while (!out_valid && lat < 50) begin
            chk("compute_in_ready", in_ready, 0);
            chk("compute_busy", busy, 1);
            if (vt[v].toggle) begin
                start    = 1'b1;
                in_valid = 1'b1;
            end
            @(negedge clock);
            lat++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("first_latency", lat, 5);
    endtask

    task automatic collect(input int v, input int abort_at, input bit chain);
        int got;
        int cyc;
        int last_hs;
        int dones;
        bit stalled;
        got = 0; cyc = 0; last_hs = 0; dones = 0; stalled = 0;
        out_ready = 1'b1;
        while (got < 16 && cyc < 1000) begin
            if (done) dones++;
            if (got == abort_at) begin
                @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_in_ready", in_ready, 0);
                for (int n = 0; n < 8; n++) begin
                    if (done) dones++;
                    @(negedge clock);
                end
                chk("abort_no_done", dones, 0);
                $display("job %0d aborted at element %0d", v, abort_at);
                return;
            end
            if (out_valid) begin
                if (got == vt[v].stall_at && !stalled) begin
                    stalled   = 1'b1;
                    out_ready = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clock);
                        cyc++;
                        chk("stall_valid", out_valid, 1);
                        chk("stall_data", out_data, vt[v].c[got]);
                        chk("stall_row", out_row, got / 4);
                        chk("stall_col", out_col, got % 4);
                    end
                    out_ready = 1'b1;
                end
                $display("job %0d C[%0d][%0d] = %0d (expected %0d)", v, out_row, out_col, out_data, vt[v].c[got]);
                chk("result_data", out_data, vt[v].c[got]);
                chk("result_row", out_row, got / 4);
                chk("result_col", out_col, got % 4);
                if (got > 0 && got != vt[v].stall_at) chk("result_gap", cyc - last_hs, 5);
                last_hs = cyc;
                got++;
            end
            @(negedge clock);
            cyc++;
        end
        chk("result_count", got, 16);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_out_valid", out_valid, 0);
        if (done) dones++;
        chk("done_count", dones, 1);
        if (chain) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("done_single", done, 0);
        if (chain) begin
            chk("chain_in_ready", in_ready, 1);
            chk("chain_busy", busy, 1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        sq_c = '{8'd90, 8'd100, 8'd110, 8'd120, 8'd202, 8'd228, 8'd254, 8'd24,
                 8'd58, 8'd100, 8'd142, 8'd184, 8'd170, 8'd228, 8'd30, 8'd88};
        for (int e = 0; e < 16; e++) begin
            vt[0].a[e] = 8'(e + 1);
            vt[0].b[e] = ((e / 4) == (e % 4)) ? 8'd1 : 8'd0;
            vt[0].c[e] = 8'(e + 1);
            vt[1].a[e] = 8'(e + 1);
            vt[1].b[e] = 8'(e + 1);
            vt[1].c[e] = sq_c[e];
            vt[2].a[e] = 8'hFF;
            vt[2].b[e] = 8'hFF;
            vt[2].c[e] = 8'h04;
            vt[3].a[e] = 8'(e + 1);
            vt[3].b[e] = 8'(e + 1);
            vt[3].c[e] = sq_c[e];
        end
        vt[0].stall_at = 5;  vt[0].toggle = 1'b0;
        vt[1].stall_at = -1; vt[1].toggle = 1'b0;
        vt[2].stall_at = -1; vt[2].toggle = 1'b0;
        vt[3].stall_at = -1; vt[3].toggle = 1'b1;

        repeat (3) @(negedge clock);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_row", out_row, 0);
        chk("reset_out_col", out_col, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            $display("job %0d start", v);
            pulse_start();
            load_body(v);
            wait_first(v);
            collect(v, -1, 1'b0);
        end

        $display("job 1 start (abort during element 7)");
        pulse_start();
        load_body(1);
        wait_first(1);
        collect(1, 6, 1'b0);

        $display("job 0 start (fresh after abort, chained restart)");
        pulse_start();
        load_body(0);
        wait_first(0);
        collect(0, -1, 1'b1);
        load_body(2);
        wait_first(2);
        collect(2, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
